seq_pattern_detector: RTL and testbench

SEQ_PATTERN_DETECTOR -- requirements
Module: seq_pattern_detector

---
 rtl/seq_pattern_detector.sv | 70 +++++++
 tb/tb_seq_pattern_detector.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/seq_pattern_detector.sv
// Serial pattern detector: shifts qualified bits into a history register and compares
// them against a loadable pattern, emitting a one-cycle pulse and a saturating match count.
module seq_pattern_detector #(
    parameter int               WIDTH     = 4,
    parameter logic [WIDTH-1:0] PATTERN   = 4'b1011,
    parameter int               OVERLAP   = 1,
    parameter int               CNT_WIDTH = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_valid,
    input  logic                 i_seq,
    input  logic                 i_load,
    input  logic [WIDTH-1:0]     i_pattern,
    input  logic                 i_clear,
    output logic                 o_check,
    output logic [CNT_WIDTH-1:0] o_count
);

    localparam int                   FILL_W    = $clog2(WIDTH + 1);
    localparam logic [FILL_W-1:0]    FILL_FULL = FILL_W'(WIDTH);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

    logic [WIDTH-1:0]  history;
    logic [WIDTH-1:0]  pattern_reg;
    logic [FILL_W-1:0] fill;

    logic              accept;
    logic [WIDTH-1:0]  next_history;
    logic [FILL_W-1:0] next_fill;
    logic              match;

    // A load edge owns the cycle, so its serial bit is never accepted.
    always_comb begin
        accept       = i_valid && !i_load;
        next_history = {history[WIDTH-2:0], i_seq};
        next_fill    = (fill == FILL_FULL) ? FILL_FULL : fill + FILL_W'(1);
        match        = accept && (next_history == pattern_reg) && (next_fill == FILL_FULL);
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            history     <= '0;
            fill        <= '0;
            pattern_reg <= PATTERN;
            o_check     <= 1'b0;
            o_count     <= '0;
        end else begin
            o_check <= 1'b0;
            if (i_load) begin
                pattern_reg <= i_pattern;
                fill        <= '0;
            end else if (i_valid) begin
                history <= next_history;
                o_check <= match;
                // Non-overlapping mode forces a fresh WIDTH bits before the next match.
                if (match && (OVERLAP == 0))
                    fill <= '0;
                else
                    fill <= next_fill;
            end

            if (i_clear)
                o_count <= '0;
            else if (match && (o_count != CNT_MAX))
                o_count <= o_count + CNT_WIDTH'(1);
        end
    end

endmodule

// File: tb/tb_seq_pattern_detector.sv
// Directed bench for seq_pattern_detector: three instances (overlap, non-overlap,
// 2-bit counter) share one stimulus bus; expected values are hand-computed per vector.
module tb_seq_pattern_detector;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       valid;
    logic       seq;
    logic       load;
    logic       clear;
    logic [3:0] pattern;

    logic       check_a;
    logic       check_b;
    logic       check_c;
    logic [7:0] count_a;
    logic [7:0] count_b;
    logic [1:0] count_c;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    seq_pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_WIDTH(8)) dut_a (
        .i_clock(clock), .i_reset_n(reset_n), .i_valid(valid), .i_seq(seq),
        .i_load(load), .i_pattern(pattern), .i_clear(clear),
        .o_check(check_a), .o_count(count_a)
    );

    seq_pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(0), .CNT_WIDTH(8)) dut_b (
        .i_clock(clock), .i_reset_n(reset_n), .i_valid(valid), .i_seq(seq),
        .i_load(load), .i_pattern(pattern), .i_clear(clear),
        .o_check(check_b), .o_count(count_b)
    );

    seq_pattern_detector #(.WIDTH(4), .PATTERN(4'b1011), .OVERLAP(1), .CNT_WIDTH(2)) dut_c (
        .i_clock(clock), .i_reset_n(reset_n), .i_valid(valid), .i_seq(seq),
        .i_load(load), .i_pattern(pattern), .i_clear(clear),
        .o_check(check_c), .o_count(count_c)
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns after the rising edge.
    task automatic applyStimulus(input logic v, input logic s, input logic l, input logic c,
                                 input logic [3:0] p);
        @(negedge clock);
        valid   = v;
        seq     = s;
        load    = l;
        clear   = c;
        pattern = p;
        @(posedge clock);
        #1;
    endtask

    task automatic sendBit(input logic s);
        applyStimulus(1'b1, s, 1'b0, 1'b0, 4'b0000);
    endtask

    task automatic applyReset();
        @(negedge clock);
        reset_n = 1'b0;
        valid   = 1'b0;
        seq     = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        pattern = 4'b0000;
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    initial begin
        logic [6:0]  stream;
        logic [4:0]  load_stream;
        logic [31:0] exp_count;

        reset_n = 1'b1;
        valid   = 1'b0;
        seq     = 1'b0;
        load    = 1'b0;
        clear   = 1'b0;
        pattern = 4'b0000;

        $display("[TB] reset values");
        applyReset();
        checkOutput("reset_check", 32'(check_a), 32'd0);
        checkOutput("reset_count", 32'(count_a), 32'd0);

        $display("[TB] overlap vs non-overlap on 1011011");
        stream = 7'b1011011;
        for (int i = 0; i < 7; i++) begin
            sendBit(stream[6-i]);
            checkOutput("ovl_check", 32'(check_a), 32'((i == 3) || (i == 6)));
            checkOutput("novl_check", 32'(check_b), 32'(i == 3));
        end
        checkOutput("ovl_count", 32'(count_a), 32'd2);
        checkOutput("novl_count", 32'(count_b), 32'd1);

        $display("[TB] idle cycles inside a partial match");
        applyReset();
        sendBit(1'b1);
        checkOutput("idle_pre1", 32'(check_a), 32'd0);
        sendBit(1'b0);
        checkOutput("idle_pre2", 32'(check_a), 32'd0);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
            checkOutput("idle_gap", 32'(check_a), 32'd0);
        end
        sendBit(1'b1);
        checkOutput("idle_post1", 32'(check_a), 32'd0);
        sendBit(1'b1);
        checkOutput("idle_match", 32'(check_a), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'b0000);
        checkOutput("idle_after_pulse", 32'(check_a), 32'd0);
        checkOutput("idle_count", 32'(count_a), 32'd1);

        $display("[TB] pattern load mid-stream");
        applyReset();
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        checkOutput("load_pre", 32'(check_a), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'b0110);
        checkOutput("load_edge", 32'(check_a), 32'd0);
        load_stream = 5'b10110;
        for (int i = 0; i < 5; i++) begin
            sendBit(load_stream[4-i]);
            checkOutput("load_check", 32'(check_a), 32'(i == 4));
        end
        checkOutput("load_count", 32'(count_a), 32'd1);

        $display("[TB] counter saturation and clear");
        applyReset();
        sendBit(1'b1);
        for (int rep = 0; rep < 6; rep++) begin
            sendBit(1'b0);
            sendBit(1'b1);
            checkOutput("sat_mid", 32'(check_c), 32'd0);
            applyStimulus(1'b1, 1'b1, 1'b0, (rep == 5), 4'b0000);
            exp_count = (rep == 5) ? 32'd0 : ((rep >= 2) ? 32'd3 : 32'(rep + 1));
            checkOutput("sat_check", 32'(check_c), 32'd1);
            checkOutput("sat_count", 32'(count_c), exp_count);
        end

        $display("[TB] asynchronous reset mid-pattern");
        applyReset();
        sendBit(1'b1);
        sendBit(1'b0);
        sendBit(1'b1);
        sendBit(1'b1);
        checkOutput("arst_pre_check", 32'(check_a), 32'd1);
        sendBit(1'b0);
        sendBit(1'b1);
        checkOutput("arst_pre_count", 32'(count_a), 32'd1);
        #1;
        reset_n = 1'b0;
        #1;
        checkOutput("arst_count", 32'(count_a), 32'd0);
        checkOutput("arst_check", 32'(check_a), 32'd0);
        @(negedge clock);
        valid = 1'b1;
        seq   = 1'b1;
        @(posedge clock);
        #1;
        checkOutput("arst_hold_count", 32'(count_a), 32'd0);
        @(negedge clock);
        valid   = 1'b0;
        reset_n = 1'b1;
        sendBit(1'b1);
        checkOutput("arst_discard", 32'(check_a), 32'd0);
        sendBit(1'b0);
        sendBit(1'b1);
        checkOutput("arst_partial", 32'(check_a), 32'd0);
        sendBit(1'b1);
        checkOutput("arst_match", 32'(check_a), 32'd1);
        checkOutput("arst_final_count", 32'(count_a), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
